// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MDU_OP_*) and their width (MDU_OP_W)
//   - two-state FSM encoding (MDU_IDLE / MDU_RUN)
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
// Ports:
//   rem      - current partial remainder (always < divisor)
//   quo      - dividend/quotient shift register; MSB is the next dividend bit
//   divisor  - divisor magnitude (non-zero)
//   rem_next - partial remainder after this step
//   quo_next - shift register with the new quotient bit shifted in at the LSB
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // trial < 2*divisor, so bit WIDTH of the difference is a clean borrow flag.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU (shift-add) and DIV/DIVU (restoring) take one radix-2 step per
// cycle; MTHI/MTLO write in a single cycle. WIDTH must be even and >= 8.
// Optional build macro: MDU_EARLY_OUT_EN - multiplies finish as soon as the
// remaining multiplier bits are all zero.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i, op_i     - issue request and op code (mdu_pkg encodings)
//   src_a_i, src_b_i  - operands (src_a_i also carries MTHI/MTLO data)
//   cancel_i          - abort in-flight operation (EX flush)
//   rd_hilo_i         - MFHI/MFLO in decode
//   busy_o            - iterative operation in flight
//   stall_o           - pipeline stall request (combinational)
//   done_o            - one-cycle pulse after HI/LO updated by an iterative op
//   hi_o, lo_o        - HI/LO registers
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    src_a_i,
  input  logic [WIDTH-1:0]    src_b_i,
  input  logic                cancel_i,
  input  logic                rd_hilo_i,
  output logic                busy_o,
  output logic                stall_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;  // |a| (multiplicand)
  logic [WIDTH-1:0] bsh;    // |b|: shifting multiplier, or static divisor
  logic [WIDTH-1:0] acc;    // product high half / partial remainder
  logic [WIDTH-1:0] plo;    // product low half / dividend-quotient shift
  logic             is_div;
  logic             q_neg;  // negate product or quotient
  logic             r_neg;  // negate remainder

  // Issue decode
  logic             iter_op, div_op, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    iter_op   = (op_i == MDU_OP_MULT) || (op_i == MDU_OP_MULTU) ||
                (op_i == MDU_OP_DIV)  || (op_i == MDU_OP_DIVU);
    div_op    = (op_i == MDU_OP_DIV)  || (op_i == MDU_OP_DIVU);
    signed_op = (op_i == MDU_OP_MULT) || (op_i == MDU_OP_DIV);
    a_neg     = signed_op & src_a_i[WIDTH-1];
    b_neg     = signed_op & src_b_i[WIDTH-1];
    a_abs     = a_neg ? ({WIDTH{1'b0}} - src_a_i) : src_a_i;
    b_abs     = b_neg ? ({WIDTH{1'b0}} - src_b_i) : src_b_i;
  end

  // Multiply step: add multiplicand when the multiplier LSB is set, then
  // shift the (WIDTH+1)-bit sum right into the {acc, plo} pair.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n, mul_lo_n;

  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, (bsh[0] ? mcand : {WIDTH{1'b0}})};
    mul_acc_n = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], plo[WIDTH-1:1]};
  end

  logic [WIDTH-1:0] div_rem_n, div_quo_n;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc),
    .quo      (plo),
    .divisor  (bsh),
    .rem_next (div_rem_n),
    .quo_next (div_quo_n)
  );

  // Completion and sign correction
  logic               early;
  logic               last;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
`ifdef MDU_EARLY_OUT_EN
    // No multiplier bits left: the rest of the product is pure shifting.
    early = !is_div && (bsh == '0);
`else
    early = 1'b0;
`endif
    last     = (cnt == CNT_W'(1)) || early;
    prod_raw = early ? ({acc, plo} >> cnt) : {mul_acc_n, mul_lo_n};
    prod_fix = q_neg ? ({(2*WIDTH){1'b0}} - prod_raw) : prod_raw;
    quo_fix  = q_neg ? ({WIDTH{1'b0}} - div_quo_n) : div_quo_n;
    rem_fix  = r_neg ? ({WIDTH{1'b0}} - div_rem_n) : div_rem_n;
  end

  assign busy_o  = (state == MDU_RUN);
  assign stall_o = busy_o & (start_i | rd_hilo_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      bsh    <= '0;
      acc    <= '0;
      plo    <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start_i && !cancel_i) begin
            if (iter_op) begin
              if (div_op && (src_b_i == '0)) begin
                hi_o   <= src_a_i;
                lo_o   <= '1;
                done_o <= 1'b1;
              end else begin
                mcand  <= a_abs;
                bsh    <= b_abs;
                acc    <= '0;
                plo    <= div_op ? a_abs : '0;
                is_div <= div_op;
                q_neg  <= a_neg ^ b_neg;
                r_neg  <= a_neg;
                cnt    <= CNT_W'(WIDTH);
                state  <= MDU_RUN;
              end
            end else if (op_i == MDU_OP_MTHI) begin
              hi_o <= src_a_i;
            end else if (op_i == MDU_OP_MTLO) begin
              lo_o <= src_a_i;
            end
          end
        end
        MDU_RUN: begin
          if (cancel_i) begin
            state <= MDU_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) begin
              acc <= div_rem_n;
              plo <= div_quo_n;
            end else begin
              acc <= mul_acc_n;
              plo <= mul_lo_n;
              bsh <= bsh >> 1;
            end
            if (last) begin
              state  <= MDU_IDLE;
              done_o <= 1'b1;
              if (is_div) begin
                hi_o <= rem_fix;
                lo_o <= quo_fix;
              end else begin
                hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                lo_o <= prod_fix[WIDTH-1:0];
              end
            end
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit (WIDTH=32, default
// build without early-out). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_i, cancel_i, rd_hilo_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .cancel_i(cancel_i),
    .rd_hilo_i(rd_hilo_i), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then watch 40 cycles (cycle 1 = first after acceptance).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy, output int done_cyc);
    nbusy = 0;
    done_cyc = -1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy_o) nbusy++;
      if (done_o && done_cyc < 0) done_cyc = c;
      if (c < 40) @(negedge clk);
    end
  endtask

  // Count done pulses over n cycles.
  task automatic watch_done(input int n, output int ndone);
    ndone = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
  endtask

  initial begin
    int nb, dc, nd;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; rd_hilo_i = 1'b0;
    op_i = 3'd0; src_a_i = '0; src_b_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;

    // Full-width unsigned multiply with latency check
    do_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, dc);
    chk("multu_busy_cycles", 64'(nb), 64'd32);
    chk("multu_done_cycle", 64'(dc), 64'd33);
    chk("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    do_op(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5, nb, dc);
    chk("mult_neg3x5", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);

    do_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, nb, dc);
    chk("div_neg7by2", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_done_cycle", 64'(dc), 64'd33);

    do_op(MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE, nb, dc);
    chk("div_7byneg2", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);

    do_op(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, dc);
    chk("div_overflow", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

    do_op(MDU_OP_DIVU, 32'd100, 32'd7, nb, dc);
    chk("divu_100by7", {hi_o, lo_o}, 64'h0000_0002_0000_000E);

    // Divide by zero
    do_op(MDU_OP_DIVU, 32'd7, 32'd0, nb, dc);
    chk("divu_by0_hilo", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
    chk("divu_by0_done", 64'(dc), 64'd1);
    chk("divu_by0_busy", 64'(nb), 64'd0);
    do_op(MDU_OP_DIV, 32'hFFFF_FFFB, 32'd0, nb, dc);
    chk("div_by0_hilo", {hi_o, lo_o}, 64'hFFFF_FFFB_FFFF_FFFF);

    // Stall and cancel with DIVU in flight; HI/LO must keep the values above
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_OP_DIVU; src_a_i = 32'd100; src_b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;                        // cycle 1
    repeat (4) @(negedge clk);             // cycle 5
    start_i = 1'b1; op_i = MDU_OP_MULTU; src_a_i = 32'd3; src_b_i = 32'd3;
    #1 chk("stall_on_start", 64'(stall_o), 64'd1);
    @(negedge clk);                        // cycle 6
    start_i = 1'b0; rd_hilo_i = 1'b1;
    #1 chk("stall_on_rdhilo", 64'(stall_o), 64'd1);
    @(negedge clk);                        // cycle 7
    rd_hilo_i = 1'b0;
    #1 chk("no_stall_busy_only", 64'(stall_o), 64'd0);
    repeat (3) @(negedge clk);             // cycle 10
    cancel_i = 1'b1;
    @(negedge clk);                        // cycle 11
    cancel_i = 1'b0;
    chk("cancel_busy", 64'(busy_o), 64'd0);
    watch_done(40, nd);
    chk("cancel_no_done", 64'(nd), 64'd0);
    chk("cancel_hilo_kept", {hi_o, lo_o}, 64'hFFFF_FFFB_FFFF_FFFF);

    // cancel beats start in IDLE
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; op_i = MDU_OP_MULTU; src_a_i = 32'd2; src_b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    chk("idle_cancel_busy", 64'(busy_o), 64'd0);

    // undefined op ignored
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd7; src_a_i = 32'h1111; src_b_i = 32'h2222;
    @(negedge clk);
    start_i = 1'b0;
    chk("badop_busy", 64'(busy_o), 64'd0);
    chk("badop_hilo_kept", {hi_o, lo_o}, 64'hFFFF_FFFB_FFFF_FFFF);
    rd_hilo_i = 1'b1;
    #1 chk("idle_no_stall", 64'(stall_o), 64'd0);
    rd_hilo_i = 1'b0;

    // MTHI / MTLO
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_OP_MTHI; src_a_i = 32'h1234;
    @(negedge clk);
    start_i = 1'b0;
    chk("mthi_hi", 64'(hi_o), 64'h1234);
    chk("mthi_no_done", 64'(done_o), 64'd0);
    chk("mthi_no_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_OP_MTLO; src_a_i = 32'h55;
    @(negedge clk);
    start_i = 1'b0;
    chk("mtlo_hilo", {hi_o, lo_o}, 64'h0000_1234_0000_0055);

    // Reset mid-operation
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_OP_MULTU; src_a_i = 32'd3; src_b_i = 32'd4;
    @(negedge clk);
    start_i = 1'b0;                        // cycle 1
    repeat (4) @(negedge clk);             // cycle 5
    rst = 1'b1;
    @(negedge clk);                        // cycle 6
    rst = 1'b0;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    watch_done(40, nd);
    chk("midrst_no_done", 64'(nd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised iterative multiply/divide unit for the 5-stage MIPS pipeline.
- Owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, plus single-cycle MTHI and MTLO.
- Sits beside the EX-stage ALU; exports a stall request that the pipeline's stall logic ORs into the existing stallF/stallD/flushE.

Parameters:
- WIDTH, 32: operand width and HI/LO register width. Must be even and ≥ 8.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  request to issue op_i in the current cycle.
- op_i  input  3  operation; encodings are in mdu_pkg.
- src_a_i  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- src_b_i  input  WIDTH  multiplier / divisor.
- cancel_i  input  1  abort the in-flight operation (EX flush).
- rd_hilo_i  input  1  an MFHI/MFLO is in decode.
- busy_o  output  1  an iterative operation is in flight.
- stall_o  output  1  pipeline stall request (combinational).
- done_o  output  1  one-cycle pulse: HI/LO just updated by an iterative op.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous): state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0, internal shift registers cleared. A reset mid-operation discards the operation; no done_o follows.
- FSM has two states.
  - IDLE: an iterative op with start_i=1 is accepted at edge E0.
    - Latch |a| and |b|, using absolute values for the signed ops.
    - Latch the sign flags: quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a).
    - Set counter=WIDTH and go to RUN.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add.
    - Divide: restoring, via the mdu_div_step sub-module.
    - Counter decrements each cycle.
    - On the edge where counter reaches 0: apply sign correction (two's-complement negate), write HI/LO, return to IDLE, set done_o=1 for the following cycle.
- Latency (fixed mode): busy_o=1 in cycles 1..WIDTH after acceptance. HI/LO show the new value and done_o=1 in cycle WIDTH+1.
- Results:
  - Multiply: {HI,LO} = 2·WIDTH-bit product.
  - Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero (DIV or DIVU): skip iteration. HI=src_a_i, LO=all ones, done_o pulses in the cycle after acceptance, busy_o never asserts.
- Signed overflow (DIV of most-negative by -1): LO=most-negative, HI=0. This falls out of the abs/negate datapath; no special case is needed.
- MTHI/MTLO in IDLE: write the target register at the accepting edge; no busy_o, no done_o.
- start_i while busy_o=1: the op is ignored and stall_o=1. The pipeline holds the instruction and reissues it.
- stall_o = busy_o & (start_i | rd_hilo_i).
- cancel_i in RUN: return to IDLE at the next edge; HI/LO unchanged; no done_o. cancel_i in IDLE is ignored.
- cancel_i and start_i in the same IDLE cycle: cancel_i wins and nothing is accepted.
- An op code that is not a defined encoding is ignored in IDLE.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in a multiply RUN cycle where the remaining multiplier shift register is zero, finish that cycle. The product is shifted into final alignment, and done_o follows as in normal completion. Latency for multiplies becomes (index of the highest set bit of |b|)+2 cycles; minimum 1 busy cycle. Divide latency is unchanged.
- Undefined: multiply latency is always exactly WIDTH busy cycles.

Decomposition:
- mdu_pkg holds:
  - MDU_OP_MULT=3'd0, MDU_OP_MULTU=3'd1, MDU_OP_DIV=3'd2, MDU_OP_DIVU=3'd3, MDU_OP_MTHI=3'd4, MDU_OP_MTLO=3'd5.
  - The op width constant.
  - FSM state encodings MDU_IDLE and MDU_RUN.
- Sub-module mdu_div_step: combinational, one restoring step. Inputs: partial remainder, quotient shift, divisor. Outputs: next partial remainder, next quotient.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy_o high cycles 1–32; done_o in cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 7 / 0 → HI=0x00000007, LO=0xFFFFFFFF; done_o next cycle; busy_o never high.
- DIVU 100/7 in flight, then:
  - cycle 5: start_i=1 → stall_o=1, op ignored;
  - cycle 6: rd_hilo_i=1 → stall_o=1;
  - cycle 10: cancel_i=1 → IDLE next cycle, no done_o, HI/LO retain their prior values.
- MTHI 0x1234 → hi_o=0x00001234 next cycle, no done_o. MULTU in flight with rst=1 at cycle 5 → next cycle busy_o=0, HI=LO=0, and done_o never pulses.
